dcache: RTL and testbench
=========================

# dcache

Direct-mapped, write-back, write-allocate data cache serving the MEM stage. It takes the load/store request driven from the EX/MEM register, returns `readData` combinationally on a hit for capture by the MEM/WB register, and asserts `stall` to freeze the pipeline while a miss is serviced against a line-wide memory handshake.

## Interface
- `LINES`, 16: number of lines (power of two); index width `IW = log2(LINES)`
- `WORDS`, 4: 32-bit words per line (fixed 4 in this revision; line = 128 bits)
- `clock`  in  1: single clock, all state updates on posedge
- `reset_n`  in  1: **synchronous, active-low reset**
- `req_valid`  in  1: load or store present in MEM (memRead | memWrite)
- `req_write`  in  1: 1 = store, 0 = load
- `req_addr`  in  32: byte address; bits [1:0] ignored
- `req_wdata`  in  32: store data
- `readData`  out  32: load data, valid on a read hit in the same cycle
- `stall`  out  1: pipeline must hold EX/MEM and stall all upstream stages
- `mem_req`  out  1: memory transaction request
- `mem_write`  out  1: 1 = line writeback, 0 = line refill
- `mem_addr`  out  32: line-aligned byte address (bits [3:0] = 0)
- `mem_wdata`  out  128: victim line for writeback
- `mem_ready`  in  1: one-cycle completion pulse from memory
- `mem_rdata`  in  128: refill line, valid when `mem_ready` = 1

## Operation
- Address split: word `[3:2]`, index `[3+IW:4]`, tag `[31:4+IW]`.
- Per line: valid, dirty, tag, 4×32 data. Hit = `req_valid & valid[idx] & tag match`.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE: read hit → `readData` = selected word, `stall` = 0. Write hit → word written at posedge, dirty set, `stall` = 0. Miss → `stall` = 1 in the same cycle; next state WRITEBACK if the victim is valid and dirty, otherwise REFILL.
- WRITEBACK: `mem_req` = 1, `mem_write` = 1, `mem_addr` = {victim tag, idx, 4'b0}, `mem_wdata` = victim line. On `mem_ready` → REFILL, clear dirty.
- REFILL: `mem_req` = 1, `mem_write` = 0, `mem_addr` = {req tag, idx, 4'b0}. On `mem_ready` → write `mem_rdata` into the line, set valid, write tag, clear dirty, go to IDLE. The request is re-evaluated in IDLE as a hit. Store miss: the store merges on that hit cycle.
- `stall` = 1 in WRITEBACK and REFILL, and combinationally in IDLE on a miss.
- `readData` = 0 when not a read hit.
- Upstream holds `req_*` stable while `stall` = 1. The cache does not latch the request.

## Timing
- Reset (`reset_n` = 0 at posedge): all valid and dirty bits cleared, state IDLE. Outputs the cycle after: `stall` = 0 with no request, `mem_req` = 0, `mem_write` = 0, `mem_addr` = 0, `mem_wdata` = 0, `readData` = 0. Data and tag arrays are not reset.
- Reset mid-miss: the transaction is abandoned and `mem_req` drops the next cycle. No line is written, even if `mem_ready` coincides with reset.
- Hit latency: 0 cycles, combinational output captured at the next posedge.
- Clean miss with `mem_ready` in the first REFILL cycle: 2 stall cycles; the 3rd cycle is a hit.
- Dirty miss: each memory transaction adds ≥1 stall cycle. `mem_req`, `mem_addr` and `mem_wdata` stay stable until the `mem_ready` cycle inclusive.
- `mem_ready` while `mem_req` = 0 is ignored.
- `req_valid` = 0 during REFILL: the refill still completes.

## Structure
- Package `dcache_pkg` holds:
  - the state enum `dcache_state_t` (IDLE/WRITEBACK/REFILL)
  - constants `ADDR_W`=32, `WORD_W`=32, `LINE_W`=128, `OFF_W`=4
  - field-extract helpers for tag and index
- One sub-module `dcache_array`: tag/valid/dirty/data storage with a combinational read port and a synchronous write port (full line, or single word plus dirty set).
- The FSM and hit logic live in `dcache`.

## Test plan
- After reset, load `0x0000_0040` → `stall` = 1. `mem_req`=1, `mem_write`=0, `mem_addr`=0x40. Pulse `mem_ready` with line {w3..w0} = {D,C,B,A} → next cycle `readData` = A, `stall` = 0.
- Store `0x0000_0044` ← 0xDEAD_BEEF on a resident line → no stall. A following load of `0x44` returns 0xDEAD_BEEF.
- Load `0x0000_0440` (same index, new tag, victim dirty) → WRITEBACK with `mem_addr`=0x40 and `mem_wdata` word1 = 0xDEAD_BEEF, then REFILL with `mem_addr`=0x440, then hit.
- Hold `mem_ready` low for 5 cycles in REFILL → `stall` and `mem_addr` held constant for all 5 cycles. No array write occurs.
- Assert `reset_n`=0 during REFILL with `mem_ready`=1 in the same cycle → next cycle `mem_req`=0. A load of the same address misses again.
- Store miss to `0x0000_0080` ← 0x1234_5678 → refill, then merge. Line is dirty, and a subsequent load returns 0x1234_5678.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types, widths and address field helpers for the data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } dcache_state_t;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int LINE_W = 128;
  localparam int OFF_W  = 4;

  // Line index: the iw bits directly above the line offset.
  function automatic logic [ADDR_W-1:0] get_index(input logic [ADDR_W-1:0] addr, input int iw);
    return (addr >> OFF_W) & ((ADDR_W'(1) << iw) - ADDR_W'(1));
  endfunction

  // Tag: everything above offset and index.
  function automatic logic [ADDR_W-1:0] get_tag(input logic [ADDR_W-1:0] addr, input int iw);
    return addr >> (OFF_W + iw);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read of one line, synchronous
// write of either a whole line (refill) or a single word (store hit).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int IW     = 4,
  parameter int TW     = 24,
  parameter int WSEL_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [IW-1:0]     idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TW-1:0]     rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              line_we,
  input  logic [TW-1:0]     wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0] wr_word,
  input  logic              dirty_clr
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TW-1:0]     tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  // Valid/dirty bookkeeping; the only storage cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end else if (dirty_clr) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  // Tag and data arrays; not reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (line_we) begin
        tag_q[idx]  <= wr_tag;
        data_q[idx] <= wr_line;
      end else if (word_we) begin
        data_q[idx][word_sel*WORD_W +: WORD_W] <= wr_word;
      end
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache with a line-wide
// memory handshake. Hits answer combinationally; misses stall the pipeline.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic [WORD_W-1:0] readData,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int IW     = $clog2(LINES);
  localparam int TW     = ADDR_W - OFF_W - IW;
  localparam int WSEL_W = $clog2(WORDS);

  dcache_state_t state_q, state_d;

  logic [IW-1:0]     req_idx;
  logic [TW-1:0]     req_tag;
  logic [WSEL_W-1:0] req_word;
  logic              unused_byte_bits;

  logic              rd_valid, rd_dirty;
  logic [TW-1:0]     rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              hit;
  logic              line_we, word_we, dirty_clr;

  assign req_idx          = IW'(get_index(req_addr, IW));
  assign req_tag          = TW'(get_tag(req_addr, IW));
  assign req_word         = req_addr[OFF_W-1:2];
  assign unused_byte_bits = ^req_addr[1:0];

  assign hit = req_valid & rd_valid & (rd_tag == req_tag);

  dcache_array #(
    .LINES (LINES),
    .IW    (IW),
    .TW    (TW),
    .WSEL_W(WSEL_W)
  ) u_array (
    .clock    (clock),
    .reset_n  (reset_n),
    .idx      (req_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .line_we  (line_we),
    .wr_tag   (req_tag),
    .wr_line  (mem_rdata),
    .word_we  (word_we),
    .word_sel (req_word),
    .wr_word  (req_wdata),
    .dirty_clr(dirty_clr)
  );

  // Miss-handling state register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, hit response and memory handshake outputs.
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    readData  = '0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    line_we   = 1'b0;
    word_we   = 1'b0;
    dirty_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            if (req_write) word_we  = 1'b1;
            else           readData = rd_line[req_word*WORD_W +: WORD_W];
          end else begin
            stall   = 1'b1;
            state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {rd_tag, req_idx, {OFF_W{1'b0}}};
        mem_wdata = rd_line;
        if (mem_ready) begin
          dirty_clr = 1'b1;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
        if (mem_ready) begin
          line_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios followed by random
// loads/stores, all checked against a line-level model of cache and memory.
module tb_dcache;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         req_valid, req_write;
  logic [31:0]  req_addr, req_wdata;
  logic [31:0]  readData;
  logic         stall, mem_req, mem_write;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  // Reference model: main memory by line address, cache lines by index.
  logic [127:0] mem_m [logic [27:0]];
  logic         cvalid [16];
  logic         cdirty [16];
  logic [27:0]  cline  [16];
  logic [127:0] cdata  [16];

  dcache u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .readData (readData),
    .stall    (stall),
    .mem_req  (mem_req),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [27:0] la);
    if (mem_m.exists(la)) return mem_m[la];
    return {4'h3, la, 4'h2, la, 4'h1, la, 4'h0, la};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      cvalid[i] = 1'b0;
      cdirty[i] = 1'b0;
    end
  endtask

  // One request from issue to completion. Called and returns at posedge+1.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int wbd, input int rfd, input logic drop);
    logic [27:0] la;
    int          ix;
    int          wi;
    logic [31:0] exp_rd;
    la = addr[31:4];
    ix = int'(addr[7:4]);
    wi = int'(addr[3:2]);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge clock);
    if (!(cvalid[ix] && cline[ix] == la)) begin
      check("miss_stall", stall, 1);
      check("miss_idle_memreq", mem_req, 0);
      @(posedge clock); #1;
      if (cvalid[ix] && cdirty[ix]) begin
        for (int k = 0; k <= wbd; k++) begin
          @(negedge clock);
          check("wb_stall", stall, 1);
          check("wb_memreq", mem_req, 1);
          check("wb_memwrite", mem_write, 1);
          check("wb_addr", mem_addr, {cline[ix], 4'h0});
          check("wb_wdata", mem_wdata, cdata[ix]);
          if (k == wbd) mem_ready = 1'b1;
          @(posedge clock); #1;
          mem_ready = 1'b0;
        end
        mem_m[cline[ix]] = cdata[ix];
        cdirty[ix] = 1'b0;
      end
      for (int k = 0; k <= rfd; k++) begin
        if (drop) req_valid = 1'b0;
        @(negedge clock);
        check("rf_stall", stall, 1);
        check("rf_memreq", mem_req, 1);
        check("rf_memwrite", mem_write, 0);
        check("rf_addr", mem_addr, {la, 4'h0});
        if (k == rfd) begin
          mem_ready = 1'b1;
          mem_rdata = line_of(la);
        end
        @(posedge clock); #1;
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      cvalid[ix] = 1'b1;
      cdirty[ix] = 1'b0;
      cline[ix]  = la;
      cdata[ix]  = line_of(la);
      req_valid  = 1'b1;
      @(negedge clock);
    end
    exp_rd = wr ? 32'h0 : cdata[ix][wi*32 +: 32];
    check("hit_stall", stall, 0);
    check("hit_memreq", mem_req, 0);
    check("hit_readdata", readData, exp_rd);
    if (wr) begin
      cdata[ix][wi*32 +: 32] = wd;
      cdirty[ix] = 1'b1;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_stall", stall, 0);
    check("rst_memreq", mem_req, 0);
    check("rst_memwrite", mem_write, 0);
    check("rst_memaddr", mem_addr, 0);
    check("rst_memwdata", mem_wdata, 0);
    check("rst_readdata", readData, 0);
    @(posedge clock); #1;

    // Clean load miss with known line, refill answered immediately
    mem_m[28'h4] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    do_req(1'b0, 32'h0000_0040, 32'h0, 0, 0, 1'b0);
    // Store hit then load back
    do_req(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 0, 0, 1'b0);
    do_req(1'b0, 32'h0000_0044, 32'h0, 0, 0, 1'b0);
    // Dirty-victim miss; refill held off for 5 cycles
    do_req(1'b0, 32'h0000_0440, 32'h0, 1, 5, 1'b0);
    check("wb_word1_in_memory", mem_m[28'h4][63:32], 32'hDEAD_BEEF);

    // Reset during REFILL with a coinciding mem_ready
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0100;
    @(negedge clock);
    check("rstmid_miss", stall, 1);
    @(posedge clock); #1;
    @(negedge clock);
    check("rstmid_refill_req", mem_req, 1);
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = {4{32'h5A5A_5A5A}};
    @(posedge clock); #1;
    reset_n = 1'b1; mem_ready = 1'b0; req_valid = 1'b0;
    model_reset();
    @(negedge clock);
    check("rstmid_memreq_dropped", mem_req, 0);
    check("rstmid_stall", stall, 0);
    @(posedge clock); #1;
    do_req(1'b0, 32'h0000_0100, 32'h0, 0, 0, 1'b0);

    // Store miss merges after refill; line then dirty
    do_req(1'b1, 32'h0000_0080, 32'h1234_5678, 0, 1, 1'b0);
    do_req(1'b0, 32'h0000_0080, 32'h0, 0, 0, 1'b0);
    do_req(1'b0, 32'h0000_0480, 32'h0, 2, 0, 1'b0);
    check("storemiss_wb", mem_m[28'h8][31:0], 32'h1234_5678);

    // mem_ready without a request is ignored
    req_valid = 1'b0; mem_ready = 1'b1; mem_rdata = {128{1'b1}};
    @(negedge clock);
    check("idle_ready_memreq", mem_req, 0);
    check("idle_ready_stall", stall, 0);
    @(posedge clock); #1;
    mem_ready = 1'b0;
    do_req(1'b0, 32'h0000_0484, 32'h0, 0, 0, 1'b0);

    // Refill completes with req_valid dropped
    do_req(1'b0, 32'h0000_0C40, 32'h0, 0, 2, 1'b1);

    // Random traffic over 4 tags x 16 lines
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      a = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
      do_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
